// File: rtl/sar_adc_dac_seq_if.sv
// Request/result bundle for the multi-channel SAR ADC/DAC sequencer.
// master drives scan requests and analog inputs; slave is the sequencer.
interface sar_adc_dac_seq_if #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] analog_in;
  logic                      start;
  logic [CHANNELS-1:0]       chan_mask;
  logic                      abort;
  logic                      busy;
  logic [WIDTH-1:0]          data_out;
  logic [CH_W-1:0]           data_ch;
  logic                      data_valid;
  logic [CHANNELS*WIDTH-1:0] analog_out;

  modport master (
    output analog_in, start, chan_mask, abort,
    input  busy, data_out, data_ch, data_valid, analog_out
  );

  modport slave (
    input  analog_in, start, chan_mask, abort,
    output busy, data_out, data_ch, data_valid, analog_out
  );
endinterface

// File: rtl/sar_adc_dac_seq.sv
// Round-robin multi-channel SAR ADC sequencer with per-channel DAC hold registers.
// Optional ADC_AVG4_EN: four conversions per channel, result is their truncated mean.
module sar_adc_dac_seq #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4
) (
  input logic              clk,
  input logic              rst,
  sar_adc_dac_seq_if.slave bus
);
  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned BIT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CHANNELS-1:0]       mask_q, mask_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [WIDTH-1:0]          held_q, held_d;
  logic [WIDTH-1:0]          sar_q, sar_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [WIDTH-1:0]          data_out_q, data_out_d;
  logic [CH_W-1:0]           data_ch_q, data_ch_d;
  logic                      valid_q, valid_d;
  logic [CHANNELS*WIDTH-1:0] dac_q, dac_d;

  logic [WIDTH-1:0]    trial;
  logic [WIDTH-1:0]    sar_step;
  logic [WIDTH-1:0]    result;
  logic [CHANNELS-1:0] rest_mask;

`ifdef ADC_AVG4_EN
  localparam int unsigned SUM_W = WIDTH + 2;
  logic [1:0]       pass_q, pass_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  assign result = WIDTH'(sum_q >> 2);
`else
  assign result = sar_q;
`endif

  function automatic logic [CH_W-1:0] lowest(input logic [CHANNELS-1:0] m);
    lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) lowest = CH_W'(i);
    end
  endfunction

  assign trial     = sar_q | (WIDTH'(1) << bit_q);
  assign sar_step  = (held_q >= trial) ? trial : sar_q;
  assign rest_mask = mask_q & ~(CHANNELS'(1) << ch_q);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    held_d     = held_q;
    sar_d      = sar_q;
    bit_d      = bit_q;
    data_out_d = data_out_q;
    data_ch_d  = data_ch_q;
    valid_d    = 1'b0;
    dac_d      = dac_q;
`ifdef ADC_AVG4_EN
    pass_d     = pass_q;
    sum_d      = sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start && (|bus.chan_mask) && !bus.abort) begin
          mask_d  = bus.chan_mask;
          ch_d    = lowest(bus.chan_mask);
          state_d = StSample;
`ifdef ADC_AVG4_EN
          pass_d  = '0;
          sum_d   = '0;
`endif
        end
      end
      StSample: begin
        held_d  = bus.analog_in[ch_q*WIDTH +: WIDTH];
        sar_d   = '0;
        bit_d   = BIT_W'(WIDTH - 1);
        state_d = StConvert;
      end
      StConvert: begin
        sar_d = sar_step;
        if (bit_q == '0) begin
`ifdef ADC_AVG4_EN
          sum_d = sum_q + SUM_W'(sar_step);
          if (pass_q == 2'd3) begin
            state_d = StDone;
          end else begin
            pass_d  = pass_q + 2'd1;
            state_d = StSample;
          end
`else
          state_d = StDone;
`endif
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      StDone: begin
        data_out_d                  = result;
        data_ch_d                   = ch_q;
        valid_d                     = 1'b1;
        dac_d[ch_q*WIDTH +: WIDTH]  = result;
        mask_d                      = rest_mask;
        if (|rest_mask) begin
          ch_d    = lowest(rest_mask);
          state_d = StSample;
`ifdef ADC_AVG4_EN
          pass_d  = '0;
          sum_d   = '0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including the DONE-cycle result and DAC write.
    if (state_q != StIdle && bus.abort) begin
      state_d    = StIdle;
      valid_d    = 1'b0;
      data_out_d = data_out_q;
      data_ch_d  = data_ch_q;
      dac_d      = dac_q;
`ifdef ADC_AVG4_EN
      sum_d      = '0;
      pass_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      ch_q       <= '0;
      held_q     <= '0;
      sar_q      <= '0;
      bit_q      <= '0;
      data_out_q <= '0;
      data_ch_q  <= '0;
      valid_q    <= 1'b0;
      dac_q      <= '0;
`ifdef ADC_AVG4_EN
      pass_q     <= '0;
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      held_q     <= held_d;
      sar_q      <= sar_d;
      bit_q      <= bit_d;
      data_out_q <= data_out_d;
      data_ch_q  <= data_ch_d;
      valid_q    <= valid_d;
      dac_q      <= dac_d;
`ifdef ADC_AVG4_EN
      pass_q     <= pass_d;
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.data_out   = data_out_q;
  assign bus.data_ch    = data_ch_q;
  assign bus.data_valid = valid_q;
  assign bus.analog_out = dac_q;
endmodule

// File: tb/tb_sar_adc_dac_seq.sv
// Directed bench for sar_adc_dac_seq: table of full scans plus hand-written
// sequences for input change, abort, ignored starts and mid-scan reset.
module tb_sar_adc_dac_seq;
  localparam int unsigned WIDTH    = 10;
  localparam int unsigned CHANNELS = 4;
`ifdef ADC_AVG4_EN
  localparam int PER_CH = 4 * (WIDTH + 1) + 1;
`else
  localparam int PER_CH = WIDTH + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_adc_dac_seq_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  sar_adc_dac_seq #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]       mask;
    logic [39:0]      ain;
    int               n;
    logic [3:0][1:0]  ch;
    logic [3:0][9:0]  data;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] dac_exp[4];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic [3:0] m, input logic [39:0] a, input int n,
                              input logic [7:0] c, input logic [39:0] d);
    mk.mask = m;
    mk.ain  = a;
    mk.n    = n;
    mk.ch   = c;
    mk.data = d;
  endfunction

  function automatic logic [39:0] dac_vec();
    dac_vec = {dac_exp[3], dac_exp[2], dac_exp[1], dac_exp[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int cyc;
    int got;
    bus.analog_in = vecs[i].ain;
    bus.chan_mask = vecs[i].mask;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    got = 0;
    check($sformatf("v%0d_busy_after_start", i), bus.busy, 1);
    while (bus.busy && cyc < 300) begin
      tick();
      cyc++;
      if (bus.data_valid) begin
        if (got < vecs[i].n) begin
          check($sformatf("v%0d_valid%0d_cycle", i, got), cyc, 1 + PER_CH * (got + 1));
          check($sformatf("v%0d_valid%0d_ch", i, got), bus.data_ch, vecs[i].ch[got]);
          check($sformatf("v%0d_valid%0d_data", i, got), bus.data_out, vecs[i].data[got]);
          dac_exp[vecs[i].ch[got]] = vecs[i].data[got];
        end
        got++;
      end
    end
    check($sformatf("v%0d_valid_count", i), got, vecs[i].n);
    check($sformatf("v%0d_busy_end", i), bus.busy, 0);
    check($sformatf("v%0d_analog_out", i), bus.analog_out, dac_vec());
    tick();
    check($sformatf("v%0d_valid_one_cycle", i), bus.data_valid, 0);
  endtask

  initial begin
    int nv;
    int cyc;

    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    int cyc;

    vecs[0] = mk(4'b0001, {10'd0, 10'd0, 10'd0, 10'd512}, 1,
                 {2'd0, 2'd0, 2'd0, 2'd0}, {10'd0, 10'd0, 10'd0, 10'd512});
    vecs[1] = mk(4'b1011, {10'd341, 10'd777, 10'd1023, 10'd0}, 3,
                 {2'd0, 2'd3, 2'd1, 2'd0}, {10'd0, 10'd341, 10'd1023, 10'd0});
    vecs[2] = mk(4'b0100, {10'd0, 10'd1, 10'd0, 10'd0}, 1,
                 {2'd0, 2'd0, 2'd0, 2'd2}, {10'd0, 10'd0, 10'd0, 10'd1});
    vecs[3] = mk(4'b1111, {10'd1023, 10'd682, 10'd1000, 10'd5}, 4,
                 {2'd3, 2'd2, 2'd1, 2'd0}, {10'd1023, 10'd682, 10'd1000, 10'd5});
    vecs[4] = mk(4'b0001, {10'd9, 10'd9, 10'd9, 10'd700}, 1,
                 {2'd0, 2'd0, 2'd0, 2'd0}, {10'd0, 10'd0, 10'd0, 10'd700});
    for (int k = 0; k < 4; k++) dac_exp[k] = '0;

    bus.analog_in = '0;
    bus.start     = 1'b0;
    bus.chan_mask = '0;
    bus.abort     = 1'b0;

    #2 rst = 1'b0;
    #20;
    check("reset_busy", bus.busy, 0);
    check("reset_valid", bus.data_valid, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_data_ch", bus.data_ch, 0);
    check("reset_analog_out", bus.analog_out, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // analog_in change after SAMPLE must not disturb the conversion
    bus.analog_in = {30'd0, 10'd512};
    bus.chan_mask = 4'b0001;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.analog_in[9:0] = 10'd100;
    nv = 0;
    cyc = 0;
    while (bus.busy && cyc < 300) begin
      tick();
      cyc++;
      if (bus.data_valid) begin
        nv++;
        check("hold_data", bus.data_out, 512);
      end
    end
    check("hold_valid_count", nv, 1);
    dac_exp[0] = 10'd512;
    check("hold_analog_out", bus.analog_out, dac_vec());

    // abort during the 5th CONVERT cycle of ch1
    bus.analog_in = {10'd0, 10'd0, 10'd300, 10'd200};
    bus.chan_mask = 4'b0011;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    nv = 0;
    while (cyc < PER_CH + 6) begin
      tick();
      cyc++;
      if (bus.data_valid) begin
        nv++;
        check("abort_ch0_ch", bus.data_ch, 0);
        check("abort_ch0_data", bus.data_out, 200);
      end
    end
    check("abort_busy_before", bus.busy, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy_after", bus.busy, 0);
    check("abort_valid_after", bus.data_valid, 0);
    dac_exp[0] = 10'd200;
    repeat (3 * PER_CH) begin
      tick();
      if (bus.data_valid) nv++;
    end
    check("abort_valid_count", nv, 1);
    check("abort_data_hold", bus.data_out, 200);
    check("abort_analog_out", bus.analog_out, dac_vec());

    // ignored starts: empty mask, start with abort, start while busy
    nv = 0;
    bus.chan_mask = 4'b0000;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_mask_busy", bus.busy, 0);
    bus.chan_mask = 4'b0001;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    repeat (15) begin
      tick();
      if (bus.data_valid) nv++;
    end
    check("ignored_no_valid", nv, 0);

    bus.analog_in = {10'd7, 10'd7, 10'd7, 10'd50};
    bus.chan_mask = 4'b0001;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.chan_mask = 4'b1111;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.chan_mask = 4'b0000;
    repeat (3 * PER_CH + 10) begin
      tick();
      if (bus.data_valid) nv++;
    end
    check("busy_start_valid_count", nv, 1);
    check("busy_start_data", bus.data_out, 50);
    check("busy_start_busy_end", bus.busy, 0);
    dac_exp[0] = 10'd50;
    check("busy_start_analog_out", bus.analog_out, dac_vec());

    // asynchronous reset in the middle of a conversion
    bus.analog_in = {10'd0, 10'd0, 10'd600, 10'd400};
    bus.chan_mask = 4'b0011;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.data_valid, 0);
    check("midrst_data_out", bus.data_out, 0);
    check("midrst_data_ch", bus.data_ch, 0);
    check("midrst_analog_out", bus.analog_out, 0);
    for (int k = 0; k < 4; k++) dac_exp[k] = '0;
    #10;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("midrst_idle_after", bus.busy, 0);

    run_vec(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
